// File: rtl/seg7_scan_if.sv
// Load-side bus of the 7-segment scan driver: packed BCD digits, decimal
// points and the single-cycle capture strobe.
interface seg7_scan_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] bcd_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;

    modport master (output bcd_in, output dp_in, output load);
    modport slave  (input  bcd_in, input  dp_in, input  load);
endinterface

// File: rtl/seg7_scan_driver.sv
// Common-anode 7-segment scan driver with shadow/active digit registers and a
// one-cycle blanking guard between slots. Optional: LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int N_DIGITS   = 4,
    parameter int PRESCALE   = 50000,
    parameter int PRESCALE_W = 16
) (
    input  logic                clk2,
    input  logic                rst_n,
    seg7_scan_if.slave          bus,
    output logic [6:0]          seg_n,
    output logic                dp_n,
    output logic [N_DIGITS-1:0] an_n,
    output logic [2:0]          digit_idx
);

    typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;

    localparam logic [PRESCALE_W-1:0] PS_LAST  = PRESCALE_W'(PRESCALE - 2);
    localparam logic [2:0]            IDX_LAST = 3'(N_DIGITS - 1);

    state_t                state, state_nxt;
    logic [PRESCALE_W-1:0] presc, presc_nxt;
    logic [4*N_DIGITS-1:0] shadow_bcd, shadow_bcd_nxt;
    logic [N_DIGITS-1:0]   shadow_dp, shadow_dp_nxt;
    logic [4*N_DIGITS-1:0] active_bcd, active_bcd_nxt;
    logic [N_DIGITS-1:0]   active_dp, active_dp_nxt;
    logic                  pending, pending_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [N_DIGITS-1:0]   an_nxt;
    logic [2:0]            idx_nxt;
    logic [3:0]            cur_val;
    logic                  cur_dp;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Digit idx is a leading zero when it and every higher digit are zero;
    // digit 0 is never blanked so an all-zero value still reads "0".
    function automatic logic lz_blank(input logic [4*N_DIGITS-1:0] v,
                                      input logic [2:0] idx);
        logic nz;
        nz = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (3'(i) >= idx && v[4*i +: 4] != 4'd0) nz = 1'b1;
        end
        lz_blank = (idx != 3'd0) && !nz;
    endfunction
`endif

    always_comb begin
        state_nxt      = state;
        presc_nxt      = presc;
        shadow_bcd_nxt = shadow_bcd;
        shadow_dp_nxt  = shadow_dp;
        active_bcd_nxt = active_bcd;
        active_dp_nxt  = active_dp;
        pending_nxt    = pending;
        seg_nxt        = seg_n;
        dp_nxt         = dp_n;
        an_nxt         = an_n;
        idx_nxt        = digit_idx;
        cur_val        = 4'd0;
        cur_dp         = 1'b0;

        case (state)
            IDLE: begin
                presc_nxt = '0;
                if (bus.load) state_nxt = GUARD;
            end
            GUARD: begin
                if (pending) begin
                    active_bcd_nxt = shadow_bcd;
                    active_dp_nxt  = shadow_dp;
                    pending_nxt    = 1'b0;
                end
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (digit_idx == 3'(i)) begin
                        cur_val = active_bcd_nxt[4*i +: 4];
                        cur_dp  = active_dp_nxt[i];
                    end
                end
                seg_nxt = seg_decode(cur_val);
`ifdef LEADING_ZERO_BLANK_EN
                if (lz_blank(active_bcd_nxt, digit_idx)) seg_nxt = 7'h7F;
`endif
                dp_nxt    = ~cur_dp;
                an_nxt    = ~(N_DIGITS'(1) << digit_idx);
                presc_nxt = '0;
                state_nxt = DRIVE;
            end
            DRIVE: begin
                if (presc == PS_LAST) begin
                    presc_nxt = '0;
                    idx_nxt   = (digit_idx == IDX_LAST) ? 3'd0 : digit_idx + 3'd1;
                    an_nxt    = '1;
                    state_nxt = GUARD;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A capture coinciding with a transfer must survive in shadow, so it
        // is applied after the FSM has possibly cleared pending.
        if (bus.load) begin
            shadow_bcd_nxt = bus.bcd_in;
            shadow_dp_nxt  = bus.dp_in;
            pending_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            active_bcd <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            an_n       <= '1;
            digit_idx  <= 3'd0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            shadow_bcd <= shadow_bcd_nxt;
            shadow_dp  <= shadow_dp_nxt;
            active_bcd <= active_bcd_nxt;
            active_dp  <= active_dp_nxt;
            pending    <= pending_nxt;
            seg_n      <= seg_nxt;
            dp_n       <= dp_nxt;
            an_n       <= an_nxt;
            digit_idx  <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at N_DIGITS=4, PRESCALE=4; expected
// patterns are hand-written constants (leading-zero cases follow the macro).
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int PS = 4;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30,
                           S4 = 7'h19, S8 = 7'h00, S9 = 7'h10, SD = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SZ = 7'h7F;
`else
    localparam logic [6:0] SZ = 7'h40;
`endif
    localparam logic [14:0] RST_V = {7'h7F, 1'b1, 4'hF, 3'd0};

    logic       clk2  = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic [2:0] digit_idx;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk2 = ~clk2;

    seg7_scan_if #(.N_DIGITS(N)) bus ();

    seg7_scan_driver #(.N_DIGITS(N), .PRESCALE(PS), .PRESCALE_W(16)) dut (
        .clk2      (clk2),
        .rst_n     (rst_n),
        .bus       (bus),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .an_n      (an_n),
        .digit_idx (digit_idx)
    );

    function automatic logic [14:0] obs();
        return {seg_n, dp_n, an_n, digit_idx};
    endfunction

    task automatic chk_vec(input string tag, input logic [14:0] o, input logic [14:0] e);
        n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL %s: got seg=%b dp=%b an=%b idx=%0d, want seg=%b dp=%b an=%b idx=%0d",
                     tag, o[14:8], o[7], o[6:3], o[2:0], e[14:8], e[7], e[6:3], e[2:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] p);
        bus.bcd_in = b;
        bus.dp_in  = p;
        bus.load   = 1'b1;
    endtask

    // Starts in the GUARD cycle of digit idx and ends in the next GUARD.
    task automatic check_slot(input logic [2:0] idx, input logic [6:0] s, input logic d,
                              input int ld_at, input logic [15:0] b1, input logic [3:0] p1,
                              input bit b2b, input logic [15:0] b2);
        chk_vec($sformatf("guard d%0d", idx), {8'd0, an_n, digit_idx}, {8'd0, 4'hF, idx});
        if (ld_at == 0) do_load(b1, p1);
        for (int k = 1; k < PS; k++) begin
            tick();
            chk_vec($sformatf("drive d%0d c%0d", idx, k), obs(),
                    {s, d, ~(4'b0001 << idx), idx});
            if (ld_at == k) do_load(b1, p1);
            else if (b2b && ld_at + 1 == k) do_load(b2, p1);
        end
        tick();
    endtask

    task automatic slot(input logic [2:0] idx, input logic [6:0] s, input logic d);
        check_slot(idx, s, d, -1, 16'h0, 4'h0, 1'b0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        bus.bcd_in = '0;
        bus.dp_in  = '0;
        bus.load   = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_vec("reset async", obs(), RST_V);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            chk_vec($sformatf("idle c%0d", c), obs(), RST_V);
        end

        do_load(16'h1234, 4'b0000);
        tick();
        slot(0, S4, 1'b1);
        slot(1, S3, 1'b1);
        slot(2, S2, 1'b1);
        slot(3, S1, 1'b1);
        slot(0, S4, 1'b1);

        check_slot(1, S3, 1'b1, 1, 16'h9999, 4'b0000, 1'b0, 16'h0);
        slot(2, S9, 1'b1);
        slot(3, S9, 1'b1);
        slot(0, S9, 1'b1);
        slot(1, S9, 1'b1);

        check_slot(2, S9, 1'b1, 3, 16'h1F34, 4'b0100, 1'b0, 16'h0);
        slot(3, S1, 1'b1);
        slot(0, S4, 1'b1);
        slot(1, S3, 1'b1);
        slot(2, SD, 1'b0);

        check_slot(3, S1, 1'b1, 2, 16'h5678, 4'b0000, 1'b0, 16'h0);
        check_slot(0, S8, 1'b1, 0, 16'h2222, 4'b0000, 1'b0, 16'h0);
        slot(1, S2, 1'b1);
        slot(2, S2, 1'b1);
        slot(3, S2, 1'b1);

        check_slot(0, S2, 1'b1, 1, 16'h4444, 4'b0000, 1'b1, 16'h3210);
        slot(1, S1, 1'b1);
        slot(2, S2, 1'b1);
        slot(3, S3, 1'b1);
        slot(0, S0, 1'b1);

        tick();
        chk_vec("pre-reset drive d1", obs(), {S1, 1'b1, 4'b1101, 3'd1});
        #2 rst_n = 1'b0;
        #1 chk_vec("reset mid-drive", obs(), RST_V);
        @(posedge clk2);
        #1 rst_n = 1'b1;
        chk_vec("reset held", obs(), RST_V);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk_vec($sformatf("post-reset idle c%0d", c), obs(), RST_V);
        end

        do_load(16'h0040, 4'b0000);
        tick();
        slot(0, S0, 1'b1);
        slot(1, S4, 1'b1);
        slot(2, SZ, 1'b1);
        check_slot(3, SZ, 1'b1, 1, 16'h0000, 4'b0010, 1'b0, 16'h0);
        slot(0, S0, 1'b1);
        slot(1, SZ, 1'b0);
        slot(2, SZ, 1'b1);
        slot(3, SZ, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
